// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver.
// Segment patterns are active-low, bit 0 = a through bit 6 = g.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index k holds the pattern for decimal digit k.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // True when any of the four nibbles is outside 0..9.
  function automatic logic has_non_bcd(input logic [15:0] val);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      bad = bad | (val[4*k+3] & (val[4*k+2] | val[4*k+1]));
    end
    return bad;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/display bundle between the BCD counter chain and the scan driver.
interface seg7_scan_driver_if;
  logic        LOAD;
  logic [15:0] DIN;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        ERR;

  modport master (output LOAD, DIN, input SEG, AN, ERR);
  modport slave  (input LOAD, DIN, output SEG, AN, ERR);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD input shows a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_DIGITS[bcd_i];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with sticky non-BCD error flag.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic                CLK,
  input  logic                RST,
  seg7_scan_driver_if.slave   bus_io
);

  localparam logic [15:0] PcntMax = 16'(SCAN_DIV - 1);

  logic [15:0]           disp_q, disp_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  err_q, err_d;
  logic                  advance;
  logic [3:0]            digit;
  logic [6:0]            dec_seg;

  // Outputs are decoded from next-state values so LOAD/advance show one edge later.
  assign digit = disp_d[{idx_d, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    advance = (pcnt_q == PcntMax);
    pcnt_d  = advance ? 16'd0 : pcnt_q + 16'd1;
    idx_d   = advance ? idx_q + 2'd1 : idx_q;
    disp_d  = bus_io.LOAD ? bus_io.DIN : disp_q;
    err_d   = err_q | (bus_io.LOAD & has_non_bcd(bus_io.DIN));
    an_d    = ~(4'b0001 << idx_d);
    seg_d   = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit k when it and every more-significant digit are zero; digit0 never blanks.
    if ((idx_d != 2'd0) && ((disp_d >> {idx_d, 2'b00}) == 16'd0)) begin
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      disp_q <= 16'd0;
      pcnt_q <= 16'd0;
      idx_q  <= 2'd0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
      err_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      err_q  <= err_d;
    end
  end

  assign bus_io.SEG = seg_q;
  assign bus_io.AN  = an_q;
  assign bus_io.ERR = err_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16: clock cycles per displayed digit, legal range 1..65535.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port LOAD, input, 1 bit: when high, DIN is captured.
REQ-005 The block SHALL have port DIN, input, 16 bits: four BCD digits from the mod-10 counter chain, digit0 = DIN[3:0] (least significant) through digit3 = DIN[15:12].
REQ-006 The block SHALL have port SEG, output, 7 bits: active-low segments, SEG[0]=a through SEG[6]=g.
REQ-007 The block SHALL have port AN, output, 4 bits: active-low digit enables, AN[k] for digit k.
REQ-008 The block SHALL have port ERR, output, 1 bit: a sticky flag indicating that a non-BCD nibble was loaded.

Function
REQ-009 The block SHALL hold a 16-bit display register DISP, with DISP <= DIN on any rising edge where RST=1 and LOAD=1.
REQ-010 The block SHALL implement a prescaler PCNT that counts 0..SCAN_DIV-1 and then wraps to 0, with the cycle where PCNT=SCAN_DIV-1 being the advance cycle.
REQ-011 The block SHALL implement a 2-bit digit index IDX that increments modulo 4 on each advance cycle (0->1->2->3->0).
REQ-012 SEG and AN SHALL be registered outputs computed from the next-state IDX and next-state DISP, so that a LOAD or an advance is visible on the outputs one edge later.
REQ-013 AN SHALL be exactly one bit low at every edge outside reset: AN = ~(4'b0001 << IDX).
REQ-014 The decode SHALL be active-low: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-015 A nibble of 0xA..0xF SHALL display as a dash, 0x3F (segment g only).
REQ-016 ERR SHALL be set on a LOAD edge where any DIN nibble is greater than 9, SHALL remain set through later valid LOADs, and SHALL clear only on reset.
REQ-017 When LOAD and an advance occur in the same cycle, the new IDX digit SHALL be shown from the new DIN value at the next edge.
REQ-018 With SCAN_DIV=1, IDX SHALL advance on every edge.

Reset
REQ-019 On a rising edge with RST=0, the block SHALL clear DISP=0, PCNT=0, IDX=0, SEG=0x7F, AN=4'hF and ERR=0, overriding LOAD, including mid-scan.
REQ-020 On the first edge with RST=1, the block SHALL drive AN=4'b1110 and SEG=decode(digit0) from the post-edge DISP.

Configuration
REQ-021 With macro LEADING_ZERO_BLANK_EN defined, digit k (k=3..1) SHALL be driven SEG=0x7F while AN[k] stays low whenever digit k and all digits above it are 0.
REQ-022 Digit0 SHALL never be blanked.
REQ-023 Without LEADING_ZERO_BLANK_EN, no blanking logic SHALL exist and zero digits SHALL show 0x40.

Structure
REQ-024 Package seg7_pkg SHALL hold the ten digit patterns, SEG_BLANK=7'h7F, SEG_DASH=7'h3F and NUM_DIGITS=4.
REQ-025 Sub-module bcd_to_seg7 SHALL be combinational: 4-bit in, 7-bit active-low out, dash for inputs greater than 9; the block SHALL instantiate it once.
REQ-026 The implementation SHALL fit within 120-400 lines of RTL in total.

Verification
REQ-027 Reset: RST=0 for 2 edges with LOAD=1 and DIN=16'h1234 -> SEG=0x7F, AN=4'hF, ERR=0, and after release SEG=0x40, AN=4'b1110.
REQ-028 Scan: SCAN_DIV=4, LOAD DIN=16'h1234 -> (AN,SEG) = (1110,0x19) for 4 cycles, then (1101,0x30), (1011,0x24), (0111,0x79), then back to (1110,0x19).
REQ-029 Invalid digit: LOAD 16'h00A7 -> digit1 SEG=0x3F and ERR=1; subsequent LOAD 16'h0001 -> ERR stays 1 and digit1 shows 0x40 (macro off) or 0x7F (macro on).
REQ-030 Blanking (macro on): DIN=16'h0105 -> digit3=0x7F, digit2=0x79, digit1=0x40, digit0=0x12; with the macro off, digit3=0x40.
REQ-031 Simultaneous event: LOAD 16'h9876 asserted on the advance cycle from IDX=0 -> next edge AN=1101, SEG=0x78.
REQ-032 Mid-scan reset: RST=0 while IDX=2 -> next edge reset values; after release the scan restarts at digit0 with SEG=0x40 and PCNT=0.
